// File: rtl/wb_burst_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : wb_burst_pkg                                            |
// | Description : Shared types and Wishbone cycle-type constants for the  |
// |               burst master and its helpers.                           |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package wb_burst_pkg;

  // Burst master control states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_e;

  // Wishbone registered-feedback cycle type identifiers.
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage
`default_nettype wire

// File: rtl/wb_burst_master_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : wb_burst_master_if                                      |
// | Description : Command, write-data, read-data, Wishbone and status     |
// |               signals of the burst master. "master" is the view of    |
// |               the burst master itself, "slave" the view of the user / |
// |               bus model on the other side.                            |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
interface wb_burst_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Command channel
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [3:0]      cmd_len;
  // Write-data channel
  logic            wdata_valid;
  logic            wdata_ready;
  logic [DW-1:0]   wdata;
  // Read-data channel (no backpressure)
  logic            rdata_valid;
  logic [DW-1:0]   rdata;
  logic            rdata_last;
  // Wishbone master side
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;
  // Status
  logic            busy;
  logic            err_o;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len,
    output cmd_ready,
    input  wdata_valid, wdata,
    output wdata_ready,
    output rdata_valid, rdata, rdata_last,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i,
    output busy, err_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len,
    input  cmd_ready,
    output wdata_valid, wdata,
    input  wdata_ready,
    input  rdata_valid, rdata, rdata_last,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i,
    input  busy, err_o
  );

endinterface
`default_nettype wire

// File: rtl/wb_ack_watchdog.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : wb_ack_watchdog                                         |
// | Description : Counts cycles in which a strobe is outstanding without  |
// |               an ack; flags expiry on the TIMEOUT-th such cycle so    |
// |               the master can abort on the following edge.             |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module wb_ack_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic enable_i,   // strobe outstanding this cycle
  input  wire logic clear_i,    // ack seen or no cycle in progress
  output logic      expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires on the cycle that would be the TIMEOUT-th unacked strobe.
  always_comb begin
    expired_o = enable_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));
    cnt_d     = cnt_q;
    if (clear_i || expired_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : wb_burst_master                                         |
// | Description : Wishbone incrementing-burst master. Accepts a command   |
// |               (addr, len = beats-1, we), then streams up to 16 beats  |
// |               with CTI signalling. Write data passes through a        |
// |               one-entry holding register; read data is registered.    |
// |               Define WB_BURST_MASTER_TIMEOUT_EN to include the ack    |
// |               watchdog (abort + err_o pulse after TIMEOUT unacked     |
// |               strobe cycles).                                         |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module wb_burst_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  wire logic         wb_clk_i,
  input  wire logic         wb_rst_i,
  wb_burst_master_if.master bus
);

  import wb_burst_pkg::*;

  localparam int            BW        = DW / 8;
  localparam logic [AW-1:0] ADDR_STEP = AW'(BW);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    len_q, len_d;
  logic          we_q, we_d;
  logic [3:0]    beat_q, beat_d;        // beats acknowledged so far
  logic [4:0]    load_q, load_d;        // write beats loaded into the holding register
  logic          hold_v_q, hold_v_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          rlast_q, rlast_d;
  logic          err_q, err_d;
  logic          ready_en_q;            // holds cmd_ready low until the first edge after reset

  logic w_cyc, w_stb, w_ack, w_last_beat, w_final;
  logic w_wr_more, w_wready, w_wload, w_cmd_ready, w_expired;

  assign w_cyc       = (state_q != IDLE);
  assign w_stb       = (state_q == RD_BURST) || ((state_q == WR_BURST) && hold_v_q);
  assign w_ack       = bus.wb_ack_i && w_stb;         // acks without a strobe are ignored
  assign w_last_beat = (beat_q == len_q);
  assign w_final     = w_ack && w_last_beat;
  assign w_wr_more   = (load_q <= {1'b0, len_q});
  assign w_wready    = (state_q == WR_BURST) && (!hold_v_q || bus.wb_ack_i) && w_wr_more;
  assign w_wload     = w_wready && bus.wdata_valid;
  assign w_cmd_ready = (state_q == IDLE) && ready_en_q;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  wb_ack_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .enable_i  (w_stb),
    .clear_i   (w_ack || !w_cyc),
    .expired_o (w_expired)
  );
`else
  // No watchdog: a burst waits indefinitely for its acks.
  assign w_expired = 1'b0;
`endif

  // Output drive.
  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.wdata_ready = w_wready;
  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_last  = rlast_q;
  assign bus.wb_cyc_o    = w_cyc;
  assign bus.wb_stb_o    = w_stb;
  assign bus.wb_we_o     = w_cyc && we_q;
  assign bus.wb_addr_o   = addr_q;
  assign bus.wb_dat_o    = hold_q;
  assign bus.wb_sel_o    = w_cyc ? {BW{1'b1}} : {BW{1'b0}};
  assign bus.wb_cti_o    = !w_cyc        ? CTI_CLASSIC :
                           (len_q == '0) ? CTI_CLASSIC :
                           w_last_beat   ? CTI_EOB     : CTI_INCR;
  assign bus.busy        = w_cyc;
  assign bus.err_o       = err_q;

  // Next-state and datapath update for the burst FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    we_d     = we_q;
    beat_d   = beat_q;
    load_d   = load_q;
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rlast_d  = 1'b0;
    err_d    = w_expired;
    case (state_q)
      IDLE: begin
        beat_d   = '0;
        load_d   = '0;
        hold_v_d = 1'b0;
        if (bus.cmd_valid && w_cmd_ready) begin
          addr_d  = bus.cmd_addr;
          len_d   = bus.cmd_len;
          we_d    = bus.cmd_we;
          state_d = bus.cmd_we ? WR_BURST : RD_BURST;
        end
      end
      WR_BURST: begin
        if (w_ack) begin
          beat_d   = beat_q + 4'd1;
          addr_d   = addr_q + ADDR_STEP;
          hold_v_d = 1'b0;
        end
        if (w_wload) begin
          hold_v_d = 1'b1;
          hold_d   = bus.wdata;
          load_d   = load_q + 5'd1;
        end
        if (w_final || w_expired) begin
          hold_v_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_BURST: begin
        if (w_ack) begin
          beat_d   = beat_q + 4'd1;
          addr_d   = addr_q + ADDR_STEP;
          rdata_d  = bus.wb_dat_i;
          rvalid_d = 1'b1;
          rlast_d  = w_last_beat;
        end
        if (w_final || w_expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      we_q       <= 1'b0;
      beat_q     <= '0;
      load_q     <= '0;
      hold_v_q   <= 1'b0;
      hold_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      we_q       <= we_d;
      beat_q     <= beat_d;
      load_q     <= load_d;
      hold_v_q   <= hold_v_d;
      hold_q     <= hold_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter AW, default 32, meaning Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width; DW/8 gives the byte-lane count.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the number of wait cycles without an ack before abort.
REQ-004 SHALL have ports wb_clk_i in 1 (the single clock) and wb_rst_i in 1 (asynchronous, active-high reset).
REQ-005 SHALL have command ports: cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_addr in AW, cmd_len in 4 (beats-1).
REQ-006 SHALL have write-data ports: wdata_valid in 1, wdata_ready out 1, wdata in DW.
REQ-007 SHALL have read-data ports: rdata_valid out 1, rdata out DW, rdata_last out 1; there is no backpressure on this port.
REQ-008 SHALL have Wishbone master ports: wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_addr_o out AW; wb_dat_o out DW; wb_sel_o out DW/8; wb_cti_o out 3; wb_ack_i in 1; wb_dat_i in DW.
REQ-009 SHALL have status ports busy out 1 and err_o out 1 (one-cycle pulse).

Function
REQ-010 SHALL implement the states IDLE, WR_BURST and RD_BURST.
REQ-011 SHALL assert cmd_ready only in IDLE; a handshake captures addr, len and we, then moves to WR_BURST or RD_BURST on the next edge.
REQ-012 SHALL assert wb_cyc_o continuously from entry to a burst state until the final ack, and deassert it in the cycle after that ack.
REQ-013 SHALL hold wb_sel_o all ones, and wb_we_o equal to the captured cmd_we, while wb_cyc_o is high.
REQ-014 SHALL drive wb_cti_o as: 3'b000 for single-beat bursts (len=0); otherwise 3'b010 on every beat except the last, and 3'b111 on the last.
REQ-015 SHALL increment wb_addr_o by DW/8 on each ack, modulo 2^AW (wrap from 0xFFFFFFFC to 0x0).
REQ-016 SHALL buffer write data in a one-entry register: wdata_ready = WR_BURST && (!hold_v || wb_ack_i), and wb_stb_o = hold_v.
REQ-017 SHALL accept no write beats beyond len+1; wdata_ready SHALL be low once the last beat is loaded.
REQ-018 SHALL hold wb_stb_o high continuously in RD_BURST until the final ack.
REQ-019 SHALL, on a read ack, register wb_dat_i to rdata and pulse rdata_valid one cycle later, with rdata_last on the final beat.
REQ-020 SHALL track beats with a 4-bit counter; the burst ends at count == len, and the block returns to IDLE.
REQ-021 SHALL assert busy whenever state != IDLE.
REQ-022 SHALL ignore wb_ack_i while wb_stb_o is low.

Reset
REQ-023 SHALL, while wb_rst_i is high, immediately force IDLE, all outputs to 0 (cmd_ready=0 during reset), and clear hold_v and the counters.
REQ-024 SHALL, on reset asserted mid-burst, drop wb_cyc_o/wb_stb_o asynchronously and discard the held data; no rdata_last is produced.
REQ-025 SHALL raise cmd_ready on the first edge after reset deasserts.

Configuration
REQ-026 SHALL implement the ack watchdog when WB_BURST_MASTER_TIMEOUT_EN is defined. The watchdog counter counts cycles with stb high and no ack, and clears on each ack. On reaching TIMEOUT it SHALL drop cyc/stb, pulse err_o for one cycle and return to IDLE. In that case remaining beats are abandoned and rdata_last is not asserted.
REQ-027 SHALL, when WB_BURST_MASTER_TIMEOUT_EN is undefined, omit the watchdog logic and tie err_o to 0; the block then waits indefinitely for an ack.

Structure
REQ-028 SHALL place the state enum and the CTI constants (CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111) in the shared package wb_burst_pkg.
REQ-029 SHALL implement the watchdog as the sub-module wb_ack_watchdog (enable, clear, expired), instantiated only under the macro.

Verification
REQ-030 SHALL cover a write with len=3 at addr 0x100 and data 0xA0..0xA3, immediate acks -> addr 0x100/104/108/10C, cti 010,010,010,111, and cyc low in the cycle after the 4th ack.
REQ-031 SHALL cover a read with len=0 at 0x40, with ack after 3 wait states and dat_i=0xDEADBEEF -> cti 000, then rdata_valid=rdata_last=1 with rdata 0xDEADBEEF one cycle after the ack.
REQ-032 SHALL cover a read with len=1 at 0xFFFFFFFC -> second beat addr 0x00000000, and rdata_last only on the 2nd beat.
REQ-033 SHALL cover a write with len=2 where wdata_valid stalls 5 cycles before beat 2 -> stb low during the stall, no extra ack counted, 3 beats total.
REQ-034 SHALL cover, with WB_BURST_MASTER_TIMEOUT_EN and TIMEOUT=8, a read with no ack -> cyc drops after 8 cycles, err_o pulses once, cmd_ready returns high.
REQ-035 SHALL cover wb_rst_i asserted during beat 2 of a len=3 write -> cyc/stb low in the same cycle, no further wdata_ready, cmd_ready=1 after release.
